// File: rtl/bcd_counter.sv
// Cascadable multi-digit BCD up counter with enable, synchronous clear, parallel load and carry.
// Define BCD_COUNTER_SAT_EN to make the counter stop at all 9s instead of wrapping.
module bcd_counter #(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  carry
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] r_q;
    logic         r_carry;
    logic [W-1:0] w_q_inc;
    logic [W-1:0] w_d_clean;
    logic         w_all_nines;

    // Digit k steps only when every lower digit is 9; the running AND doubles as the all-9s flag.
    always_comb begin
        logic       v_ripple;
        logic [3:0] v_digit;
        // NOTE: every output of this block is given a value before any branch, so no latch can form.
        v_ripple  = 1'b1;
        v_digit   = '0;
        w_q_inc   = '0;
        w_d_clean = '0;
        for (int k = 0; k < DIGITS; k++) begin
            v_digit = r_q[4*k +: 4];
            if (v_ripple) begin
                w_q_inc[4*k +: 4] = (v_digit == 4'd9) ? 4'd0 : v_digit + 4'd1;
            end else begin
                w_q_inc[4*k +: 4] = v_digit;
            end
            v_ripple = v_ripple && (v_digit == 4'd9);
            w_d_clean[4*k +: 4] = (d[4*k +: 4] > 4'd9) ? 4'd0 : d[4*k +: 4];
        end
        w_all_nines = v_ripple;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= '0;
            r_carry <= 1'b0;
        end else if (clr) begin
            r_q     <= '0;
            r_carry <= 1'b0;
        end else if (load) begin
            r_q     <= w_d_clean;
            r_carry <= 1'b0;
        end else if (en) begin
`ifdef BCD_COUNTER_SAT_EN
            if (!w_all_nines) begin
                r_q <= w_q_inc;
            end
            r_carry <= 1'b0;
`else
            r_q     <= w_q_inc;
            r_carry <= w_all_nines;
`endif
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign q     = r_q;
    assign carry = r_carry;
    assign tc    = reset & en & w_all_nines;

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: directed steps then random traffic on a 1-digit
// and a 2-digit instance, each compared against an integer-valued decimal model.
module tb_bcd_counter;

    logic       clk;
    logic       reset;
    logic       en1, clr1, load1;
    logic [3:0] d1, q1;
    logic       tc1, carry1;
    logic       en2, clr2, load2;
    logic [7:0] d2, q2;
    logic       tc2, carry2;

    int checks   = 0;
    int failures = 0;
    int m1 = 0, m2 = 0;           // model counts as plain integers
    logic mc1 = 1'b0, mc2 = 1'b0; // model carry

    bcd_counter #(.DIGITS(1)) dut1 (
        .clk(clk), .reset(reset), .en(en1), .clr(clr1), .load(load1),
        .d(d1), .q(q1), .tc(tc1), .carry(carry1)
    );

    bcd_counter #(.DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .en(en2), .clr(clr2), .load(load2),
        .d(d2), .q(q2), .tc(tc2), .carry(carry2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Integer value of a load word; a digit above 9 contributes 0.
    function automatic int load_value(input logic [31:0] d, input int digits);
        int v = 0;
        for (int k = 0; k < digits; k++) begin
            int nib = int'((d >> (4 * k)) & 32'hF);
            if (nib <= 9) v = v + nib * pow10(k);
        end
        return v;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int digits);
        logic [31:0] r = '0;
        int rem = v;
        for (int k = 0; k < digits; k++) begin
            r = r | (32'(rem % 10) << (4 * k));
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic model_step(input int v, input int digits, input logic en, input logic clr,
                              input logic load, input logic [31:0] d,
                              output int nv, output logic nc);
        int max = pow10(digits) - 1;
        nc = 1'b0;
        if (clr)       nv = 0;
        else if (load) nv = load_value(d, digits);
        else if (en) begin
            if (v == max) begin
`ifdef BCD_COUNTER_SAT_EN
                nv = v;
`else
                nv = 0;
                nc = 1'b1;
`endif
            end else begin
                nv = v + 1;
            end
        end else nv = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("q1", 32'(q1), to_bcd(m1, 1));
        check("carry1", 32'(carry1), 32'(mc1));
        check("tc1", 32'(tc1), 32'(reset && en1 && m1 == 9));
        check("q2", 32'(q2), to_bcd(m2, 2));
        check("carry2", 32'(carry2), 32'(mc2));
        check("tc2", 32'(tc2), 32'(reset && en2 && m2 == 99));
    endtask

    // Advance one clock: update the model with the inputs present at the edge, then compare.
    task automatic tick();
        int   n1, n2;
        logic c1, c2;
        @(posedge clk);
        if (!reset) begin
            n1 = 0; n2 = 0; c1 = 1'b0; c2 = 1'b0;
        end else begin
            model_step(m1, 1, en1, clr1, load1, 32'(d1), n1, c1);
            model_step(m2, 2, en2, clr2, load2, 32'(d2), n2, c2);
        end
        #1;
        m1 = n1; m2 = n2; mc1 = c1; mc2 = c2;
        check_all();
    endtask

    initial begin
        reset = 1'b0;
        en1 = 1'b1; clr1 = 1'b0; load1 = 1'b0; d1 = '0;
        en2 = 1'b0; clr2 = 1'b0; load2 = 1'b0; d2 = '0;
        #1;
        check_all();
        #11 reset = 1'b1;

        // 1-digit count 1..9, 0, 1 with a single carry after the wrap
        for (int i = 0; i < 11; i++) tick();

        // count up to 5, then asynchronous reset between edges
        for (int i = 0; i < 4; i++) tick();
        #3 reset = 1'b0;
        #1;
        m1 = 0; m2 = 0; mc1 = 1'b0; mc2 = 1'b0;
        check_all();
        #9 reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // enable low for three clocks at 4, then resume
        en1 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        en1 = 1'b1;
        tick();

        // 2-digit: load 98, count through 99 -> 00 -> 01
        load2 = 1'b1; d2 = 8'h98; en2 = 1'b1;
        tick();
        load2 = 1'b0;
        #1 check_all();
        for (int i = 0; i < 3; i++) tick();

        // non-BCD load digit, then clear beats load, then mixed bad/good digits
        load2 = 1'b1; d2 = 8'hA7;
        tick();
        clr2 = 1'b1; d2 = 8'h55;
        tick();
        clr2 = 1'b0; d2 = 8'h9C;
        tick();
        load2 = 1'b0;

        // random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            en1   = ($urandom_range(0, 3) != 0);
            clr1  = ($urandom_range(0, 19) == 0);
            load1 = ($urandom_range(0, 9) == 0);
            d1    = 4'($urandom);
            en2   = ($urandom_range(0, 3) != 0);
            clr2  = ($urandom_range(0, 19) == 0);
            load2 = ($urandom_range(0, 9) == 0);
            d2    = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d2 = 8'h99;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
